// File: rtl/puf_measure_ctrl.sv
// Ring-oscillator PUF measurement sequencer.
// Runs one clear / count-window / settle / compare cycle per accepted start.
// The result is one response bit plus a tie flag and a margin |A-B|.
// Every output is a register, and control outputs are decoded from the next state.
module puf_measure_ctrl #(
   parameter int SIZE    = 32,
   parameter int SEL_W   = 4,
   parameter int CLR_CYC = 2,
   parameter int WINDOW  = 1024,
   parameter int SETTLE  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [2*SEL_W-1:0] challenge,
   input  logic [SIZE-1:0]    cnt_a,
   input  logic [SIZE-1:0]    cnt_b,
   output logic [SEL_W-1:0]   sel_a,
   output logic [SEL_W-1:0]   sel_b,
   output logic               cnt_reset,
   output logic               cnt_en,
   output logic               busy,
   output logic               done,
   output logic               resp_bit,
   output logic               tie,
   output logic [SIZE-1:0]    diff
);

   // The phase counter must be able to hold the longest of the three timed phases.
   localparam int MAX_A = (CLR_CYC > WINDOW) ? CLR_CYC : WINDOW;
   localparam int MAX_C = (MAX_A > SETTLE) ? MAX_A : SETTLE;
   localparam int CW    = $clog2(MAX_C + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_MEASURE,
      ST_SETTLE,
      ST_COMPARE,
      ST_RESULT
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   phase;
   logic [SIZE-1:0] abs_diff;

   // Unsigned magnitude of the difference. Subtracting the smaller count from the larger one avoids wrap.
   assign abs_diff = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);

   // State register and per-phase cycle counter. The counter restarts on every state change.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state <= ST_IDLE;
         phase <= '0;
      end else begin
         state <= state_nx;
         if (state_nx != state || state == ST_IDLE)
            phase <= '0;
         else
            phase <= phase + CW'(1);
      end
   end

   // Next-state decode. Each timed phase ends when its counter reaches its length minus one.
   always_comb begin
      // NOTE: default first, so that no path through the case leaves state_nx unassigned (no latch).
      state_nx = state;
      case (state)
         ST_IDLE:    if (start) state_nx = ST_CLEAR;
         ST_CLEAR:   if (phase == CW'(CLR_CYC - 1)) state_nx = ST_MEASURE;
         ST_MEASURE: if (phase == CW'(WINDOW - 1))  state_nx = ST_SETTLE;
         ST_SETTLE:  if (phase == CW'(SETTLE - 1))  state_nx = ST_COMPARE;
         ST_COMPARE: state_nx = ST_RESULT;
         ST_RESULT:  state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // Registered outputs. Controls follow the next state, so they align with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_a     <= '0;
         sel_b     <= '0;
         cnt_reset <= 1'b1;
         cnt_en    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         resp_bit  <= 1'b0;
         tie       <= 1'b0;
         diff      <= '0;
      end else begin
         if (state == ST_IDLE && start) begin
            sel_a <= challenge[2*SEL_W-1:SEL_W];
            sel_b <= challenge[SEL_W-1:0];
         end
         cnt_reset <= (state_nx == ST_CLEAR);
         cnt_en    <= (state_nx == ST_MEASURE);
         busy      <= (state_nx != ST_IDLE);
         done      <= (state_nx == ST_RESULT);
         // Counts are taken in the COMPARE cycle. The results then hold until the next compare.
         if (state == ST_COMPARE) begin
            resp_bit <= (cnt_a > cnt_b);
            tie      <= (cnt_a == cnt_b);
            diff     <= abs_diff;
         end
      end
   end

endmodule

// File: doc/puf_measure_ctrl.md
PUF_MEASURE_CTRL -- requirements
Module: puf_measure_ctrl

Interface
REQ-001 Parameter SIZE, default 32: width of each ring-oscillator edge-count input.
REQ-002 Parameter SEL_W, default 4: width of each oscillator-select output.
REQ-003 Parameter CLR_CYC, default 2: number of cycles the counter clear is held.
REQ-004 Parameter WINDOW, default 1024: number of cycles the counter enable is held; legal range is at least 1.
REQ-005 Parameter SETTLE, default 4: number of idle cycles between enable drop and count sampling; legal range is at least 1.
REQ-006 Port clk, input, 1 bit: system clock; one clock, all state on rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port start, input, 1 bit: measurement request, sampled only in IDLE.
REQ-009 Port challenge, input, 2*SEL_W bits: [2*SEL_W-1:SEL_W] selects oscillator A, [SEL_W-1:0] selects oscillator B.
REQ-010 Port cnt_a and cnt_b, inputs, SIZE bits each: count values of the two edge counters.
REQ-011 Port sel_a and sel_b, outputs, SEL_W bits each: latched oscillator selects driving the RO muxes.
REQ-012 Port cnt_reset, output, 1 bit: clear to both edge counters.
REQ-013 Port cnt_en, output, 1 bit: enable to both edge counters.
REQ-014 Port busy, output, 1 bit: high while a measurement is in progress.
REQ-015 Port done, output, 1 bit: one-cycle result strobe.
REQ-016 Port resp_bit, output, 1 bit: PUF response bit.
REQ-017 Port tie, output, 1 bit: high when the two counts were equal.
REQ-018 Port diff, output, SIZE bits: |cnt_a - cnt_b|, used as a reliability margin.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, MEASURE, SETTLE, COMPARE and RESULT; every output SHALL be registered.
REQ-020 In IDLE, start=1 at cycle T SHALL latch challenge into sel_a/sel_b and enter CLEAR at T+1; start=0 SHALL keep the FSM in IDLE.
REQ-021 In CLEAR, cnt_reset=1 and cnt_en=0 for exactly CLR_CYC cycles, then MEASURE.
REQ-022 In MEASURE, cnt_reset=0 and cnt_en=1 for exactly WINDOW cycles, then SETTLE.
REQ-023 In SETTLE, cnt_en=0 and cnt_reset=0 for exactly SETTLE cycles, then COMPARE.
REQ-024 In COMPARE (one cycle), cnt_a/cnt_b SHALL be captured and the FSM SHALL go to RESULT.
REQ-025 In RESULT (one cycle), done=1 with resp_bit=(captured A > captured B), tie=(A==B), and diff=|A-B|, all computed unsigned at SIZE bits with no wrap of the difference; then IDLE.
REQ-026 With start at cycle T, done SHALL be high exactly in cycle T+CLR_CYC+WINDOW+SETTLE+2.
REQ-027 busy SHALL be 1 from T+1 through the done cycle inclusive, and 0 otherwise.
REQ-028 start SHALL be ignored whenever the FSM is not in IDLE, including the done cycle; a new start is accepted the cycle after done.
REQ-029 A change on challenge while busy SHALL NOT affect sel_a/sel_b.
REQ-030 resp_bit, tie and diff SHALL hold their values until the next RESULT or reset; in IDLE, cnt_en=0 and cnt_reset=0, so the last counts remain readable.
REQ-031 On a tie, resp_bit SHALL be 0.
REQ-032 Window and phase counters SHALL be sized to hold max(CLR_CYC, WINDOW, SETTLE) without overflow.

Reset
REQ-033 reset=1 at a clock edge SHALL force IDLE with busy=0, done=0, cnt_en=0, cnt_reset=1 (that cycle only), sel_a=sel_b=0, resp_bit=0, tie=0, diff=0, and all phase counters cleared.
REQ-034 reset SHALL take priority over start and over any state, including reset mid-MEASURE; the next measurement SHALL be a full CLEAR/MEASURE/SETTLE sequence.

Verification (CLR_CYC=2, WINDOW=16, SETTLE=4, SIZE=32, SEL_W=4)
REQ-035 Scenario: start at cycle 10, challenge=0x3A, cnt_a=500, cnt_b=480 -> sel_a=3, sel_b=0xA; cnt_reset is high in cycles 11-12; cnt_en is high in cycles 13-28; done is high in cycle 34 with resp_bit=1, tie=0, diff=20.
REQ-036 Scenario: cnt_a=480, cnt_b=500 -> resp_bit=0, diff=20; cnt_a=cnt_b=777 -> resp_bit=0, tie=1, diff=0.
REQ-037 Scenario: start pulses during MEASURE and during the done cycle, and challenge is changed mid-run -> exactly one done; sel values unchanged; next start accepted one cycle after done.
REQ-038 Scenario: reset asserted at MEASURE cycle 5 -> next cycle busy=0 and cnt_en=0, with all outputs at reset values; a subsequent start yields a full-length run of 24 cycles from start to done.
REQ-039 Scenario: cnt_a=0xFFFFFFFF, cnt_b=0 -> resp_bit=1, diff=0xFFFFFFFF; cnt_a/cnt_b changing during SETTLE -> the value present in the COMPARE cycle is used.
REQ-040 Scenario: start held high continuously -> back-to-back runs, each done spaced 25 cycles apart.
